// File: rtl/kv_txn_responder.sv
// kv_txn_responder: single-outstanding key/value transaction engine.
// A request key is resolved through two hash tables (cuckoo-style placement,
// table 1 preferred) to a value address; the value memory is then inserted,
// read, credited/debited or the key deleted, and a status/value/address
// response is returned over a valid/ready handshake.
module kv_txn_responder #(
  parameter int KEY_WIDTH     = 32,
  parameter int VAL_WIDTH     = 32,
  parameter int ADDR_BITS     = 4,
  parameter int VAL_ADDR_BITS = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [KEY_WIDTH-1:0]     req_key,
  input  logic [1:0]               req_signal,
  input  logic [VAL_WIDTH-1:0]     req_value,
  input  logic                     req_kind,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [1:0]               resp_status,
  output logic [VAL_WIDTH-1:0]     resp_value,
  output logic [VAL_ADDR_BITS-1:0] resp_value_addr
);

  localparam int SLOTS  = 1 << ADDR_BITS;
  localparam int VDEPTH = 1 << VAL_ADDR_BITS;

  typedef enum logic [2:0] {S_IDLE, S_PROBE, S_MATCH, S_VREAD, S_UPDATE, S_RESP} state_t;
  typedef enum logic [1:0] {OP_TRANSACT, OP_INSERT, OP_LOOKUP, OP_DELETE} op_t;
  typedef enum logic [1:0] {ST_OK, ST_NOT_FOUND, ST_FULL, ST_REJECT} status_t;

  state_t                   state_q, state_d;
  op_t                      op_q, op_d;
  status_t                  status_q, status_d;
  logic [KEY_WIDTH-1:0]     key_q, key_d;
  logic [VAL_WIDTH-1:0]     amt_q, amt_d;
  logic                     kind_q, kind_d;
  logic                     p1_valid_q, p1_valid_d, p2_valid_q, p2_valid_d;
  logic [KEY_WIDTH-1:0]     p1_key_q, p1_key_d, p2_key_q, p2_key_d;
  logic [VAL_ADDR_BITS-1:0] p1_addr_q, p1_addr_d, p2_addr_q, p2_addr_d;
  logic [VAL_ADDR_BITS-1:0] hit_addr_q, hit_addr_d;
  logic [VAL_WIDTH-1:0]     old_q, old_d;
  logic [VAL_WIDTH-1:0]     rvalue_q, rvalue_d;
  logic [VAL_ADDR_BITS-1:0] raddr_q, raddr_d;
  logic [VAL_ADDR_BITS:0]   alloc_q, alloc_d;
  logic [SLOTS-1:0]         t1_valid_q, t1_valid_d, t2_valid_q, t2_valid_d;

  // Key/address/value storage is deliberately not reset.
  logic [KEY_WIDTH-1:0]     t1_key_mem  [SLOTS];
  logic [VAL_ADDR_BITS-1:0] t1_addr_mem [SLOTS];
  logic [KEY_WIDTH-1:0]     t2_key_mem  [SLOTS];
  logic [VAL_ADDR_BITS-1:0] t2_addr_mem [SLOTS];
  logic [VAL_WIDTH-1:0]     val_mem     [VDEPTH];

  logic [ADDR_BITS-1:0]     h1, h2;
  logic                     hit1, hit2;
  logic                     t1_we, t2_we, vm_we;
  logic [VAL_ADDR_BITS-1:0] vm_waddr;
  logic [VAL_WIDTH-1:0]     vm_wdata;

  assign h1 = key_q[ADDR_BITS-1:0];
  assign h2 = key_q[2*ADDR_BITS-1:ADDR_BITS] ^ key_q[3*ADDR_BITS-1:2*ADDR_BITS];
  assign hit1 = p1_valid_q && (p1_key_q == key_q);
  assign hit2 = p2_valid_q && (p2_key_q == key_q);

  assign req_ready       = (state_q == S_IDLE);
  assign resp_valid      = (state_q == S_RESP);
  assign resp_status     = status_q;
  assign resp_value      = rvalue_q;
  assign resp_value_addr = raddr_q;

  // Next-state, datapath and memory write-enable logic.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    status_d   = status_q;
    key_d      = key_q;
    amt_d      = amt_q;
    kind_d     = kind_q;
    p1_valid_d = p1_valid_q;
    p1_key_d   = p1_key_q;
    p1_addr_d  = p1_addr_q;
    p2_valid_d = p2_valid_q;
    p2_key_d   = p2_key_q;
    p2_addr_d  = p2_addr_q;
    hit_addr_d = hit_addr_q;
    old_d      = old_q;
    rvalue_d   = rvalue_q;
    raddr_d    = raddr_q;
    alloc_d    = alloc_q;
    t1_valid_d = t1_valid_q;
    t2_valid_d = t2_valid_q;
    t1_we      = 1'b0;
    t2_we      = 1'b0;
    vm_we      = 1'b0;
    vm_waddr   = hit_addr_q;
    vm_wdata   = old_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          key_d   = req_key;
          op_d    = op_t'(req_signal);
          amt_d   = req_value;
          kind_d  = req_kind;
          state_d = S_PROBE;
        end
      end
      S_PROBE: begin
        p1_valid_d = t1_valid_q[h1];
        p1_key_d   = t1_key_mem[h1];
        p1_addr_d  = t1_addr_mem[h1];
        p2_valid_d = t2_valid_q[h2];
        p2_key_d   = t2_key_mem[h2];
        p2_addr_d  = t2_addr_mem[h2];
        state_d    = S_MATCH;
      end
      S_MATCH: begin
        hit_addr_d = hit1 ? p1_addr_q : p2_addr_q;
        rvalue_d   = '0;
        raddr_d    = '0;
        state_d    = S_RESP;
        case (op_q)
          OP_INSERT: begin
            if (hit1 || hit2) begin
              status_d = ST_REJECT;
              raddr_d  = hit_addr_d;
            end else if (!alloc_q[VAL_ADDR_BITS] && (!p1_valid_q || !p2_valid_q)) begin
              if (!p1_valid_q) begin
                t1_we          = 1'b1;
                t1_valid_d[h1] = 1'b1;
              end else begin
                t2_we          = 1'b1;
                t2_valid_d[h2] = 1'b1;
              end
              vm_we    = 1'b1;
              vm_waddr = alloc_q[VAL_ADDR_BITS-1:0];
              vm_wdata = amt_q;
              alloc_d  = alloc_q + 1'b1;
              status_d = ST_OK;
              rvalue_d = amt_q;
              raddr_d  = alloc_q[VAL_ADDR_BITS-1:0];
            end else begin
              status_d = ST_FULL;
            end
          end
          OP_DELETE: begin
            if (hit1 || hit2) begin
              if (hit1) t1_valid_d[h1] = 1'b0;
              else      t2_valid_d[h2] = 1'b0;
              status_d = ST_OK;
              raddr_d  = hit_addr_d;
            end else begin
              status_d = ST_NOT_FOUND;
            end
          end
          default: begin
            if (hit1 || hit2) begin
              raddr_d = hit_addr_d;
              state_d = S_VREAD;
            end else begin
              status_d = ST_NOT_FOUND;
            end
          end
        endcase
      end
      S_VREAD: begin
        old_d   = val_mem[hit_addr_q];
        state_d = S_UPDATE;
      end
      S_UPDATE: begin
        status_d = ST_OK;
        rvalue_d = old_q;
        state_d  = S_RESP;
        if (op_q == OP_TRANSACT) begin
          if (!kind_q) begin
            vm_we    = 1'b1;
            vm_wdata = old_q + amt_q;
            rvalue_d = vm_wdata;
          end else if (amt_q > old_q) begin
            status_d = ST_REJECT;
          end else begin
            vm_we    = 1'b1;
            vm_wdata = old_q - amt_q;
            rvalue_d = vm_wdata;
          end
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, request latches, probe registers, valid bits, allocator.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= OP_TRANSACT;
      status_q   <= ST_OK;
      key_q      <= '0;
      amt_q      <= '0;
      kind_q     <= 1'b0;
      p1_valid_q <= 1'b0;
      p1_key_q   <= '0;
      p1_addr_q  <= '0;
      p2_valid_q <= 1'b0;
      p2_key_q   <= '0;
      p2_addr_q  <= '0;
      hit_addr_q <= '0;
      old_q      <= '0;
      rvalue_q   <= '0;
      raddr_q    <= '0;
      alloc_q    <= '0;
      t1_valid_q <= '0;
      t2_valid_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      status_q   <= status_d;
      key_q      <= key_d;
      amt_q      <= amt_d;
      kind_q     <= kind_d;
      p1_valid_q <= p1_valid_d;
      p1_key_q   <= p1_key_d;
      p1_addr_q  <= p1_addr_d;
      p2_valid_q <= p2_valid_d;
      p2_key_q   <= p2_key_d;
      p2_addr_q  <= p2_addr_d;
      hit_addr_q <= hit_addr_d;
      old_q      <= old_d;
      rvalue_q   <= rvalue_d;
      raddr_q    <= raddr_d;
      alloc_q    <= alloc_d;
      t1_valid_q <= t1_valid_d;
      t2_valid_q <= t2_valid_d;
    end
  end

  // Table key/address and value memory writes (unreset storage).
  always_ff @(posedge clock) begin
    if (t1_we) begin
      t1_key_mem[h1]  <= key_q;
      t1_addr_mem[h1] <= alloc_q[VAL_ADDR_BITS-1:0];
    end
    if (t2_we) begin
      t2_key_mem[h2]  <= key_q;
      t2_addr_mem[h2] <= alloc_q[VAL_ADDR_BITS-1:0];
    end
    if (vm_we) val_mem[vm_waddr] <= vm_wdata;
  end

endmodule

// File: tb/tb_kv_txn_responder.sv
// Self-checking bench for kv_txn_responder: directed scenarios plus randomized
// traffic, checked against a behavioural key/value store model.
module tb_kv_txn_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_key = '0;
  logic [1:0]  req_signal = '0;
  logic [31:0] req_value = '0;
  logic        req_kind = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [1:0]  resp_status;
  logic [31:0] resp_value;
  logic [4:0]  resp_value_addr;

  int n_checks = 0;
  int n_errors = 0;

  kv_txn_responder #(.KEY_WIDTH(32), .VAL_WIDTH(32), .ADDR_BITS(4), .VAL_ADDR_BITS(5)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
    .req_signal(req_signal), .req_value(req_value), .req_kind(req_kind),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_status(resp_status),
    .resp_value(resp_value), .resp_value_addr(resp_value_addr)
  );

  always #5 clock = ~clock;

  // Reference store: two 16-slot hash tables, balances by address, allocator.
  bit          mv1 [16];
  bit          mv2 [16];
  logic [31:0] mk1 [16];
  logic [31:0] mk2 [16];
  int          ma1 [16];
  int          ma2 [16];
  logic [31:0] bal [32];
  int          alloc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mv1[i] = 1'b0;
      mv2[i] = 1'b0;
    end
    alloc = 0;
  endtask

  // Expected outcome of one request, applied to the model state.
  task automatic model_op(input logic [31:0] key, input logic [1:0] sig, input logic [31:0] v,
                          input logic kind, output int st, output logic [31:0] rv,
                          output int ra, output int lat, output bit chkv);
    int  s1, s2, a;
    bit  hit1, hit2;
    s1   = int'(key[3:0]);
    s2   = int'(key[7:4] ^ key[11:8]);
    hit1 = mv1[s1] && (mk1[s1] == key);
    hit2 = mv2[s2] && (mk2[s2] == key);
    a    = hit1 ? ma1[s1] : ma2[s2];
    lat  = 3;
    rv   = '0;
    ra   = 0;
    chkv = 1'b1;
    st   = 1;
    if (sig == 2'd1) begin
      if (hit1 || hit2) begin
        st = 3; ra = a; chkv = 1'b0;
      end else if (alloc < 32 && (!mv1[s1] || !mv2[s2])) begin
        if (!mv1[s1]) begin mv1[s1] = 1'b1; mk1[s1] = key; ma1[s1] = alloc; end
        else          begin mv2[s2] = 1'b1; mk2[s2] = key; ma2[s2] = alloc; end
        bal[alloc] = v;
        st = 0; rv = v; ra = alloc;
        alloc++;
      end else begin
        st = 2;
      end
    end else if (sig == 2'd3) begin
      if (hit1 || hit2) begin
        if (hit1) mv1[s1] = 1'b0;
        else      mv2[s2] = 1'b0;
        st = 0; ra = a; chkv = 1'b0;
      end
    end else if (hit1 || hit2) begin
      lat = 5;
      ra  = a;
      st  = 0;
      if (sig == 2'd0) begin
        if (!kind) bal[a] = bal[a] + v;
        else if (v > bal[a]) st = 3;
        else bal[a] = bal[a] - v;
      end
      rv = bal[a];
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    check("req_ready_wait", 64'(req_ready), 64'(1));
  endtask

  // Send one request and compare the response against the model.
  task automatic do_op(input logic [31:0] key, input logic [1:0] sig,
                       input logic [31:0] v, input logic kind);
    int st, ra, elat, lat;
    logic [31:0] rv;
    bit chkv;
    model_op(key, sig, v, kind, st, rv, ra, elat, chkv);
    wait_ready();
    req_valid = 1'b1; req_key = key; req_signal = sig; req_value = v; req_kind = kind;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(elat));
    check("status", 64'(resp_status), 64'(st));
    if (chkv) check("value", 64'(resp_value), 64'(rv));
    check("addr", 64'(resp_value_addr), 64'(ra));
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin : main
    logic [31:0] pool [20];
    logic [31:0] hv;
    int st, ra, elat, n;
    bit chkv;

    model_reset();
    reset = 1'b1;
    #12;
    check("rst_req_ready", 64'(req_ready), 64'(1));
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_status", 64'(resp_status), 64'(0));
    check("rst_value", 64'(resp_value), 64'(0));
    check("rst_addr", 64'(resp_value_addr), 64'(0));
    @(posedge clock); #1;
    reset = 1'b0;

    // Balance arithmetic on key 249.
    do_op(32'd249, 2'd1, 32'd100, 1'b0);
    do_op(32'd249, 2'd0, 32'd50, 1'b0);
    do_op(32'd249, 2'd2, 32'd0, 1'b0);
    do_op(32'd249, 2'd0, 32'd200, 1'b1);
    do_op(32'd249, 2'd2, 32'd0, 1'b0);
    do_op(32'd249, 2'd0, 32'd150, 1'b1);
    do_op(32'd249, 2'd0, 32'hFFFF_FFFF, 1'b0);
    do_op(32'd249, 2'd0, 32'd2, 1'b0);

    // Backpressure: response held, new requests ignored.
    model_op(32'd249, 2'd2, 32'd0, 1'b0, st, hv, ra, elat, chkv);
    wait_ready();
    req_valid = 1'b1; req_key = 32'd249; req_signal = 2'd2;
    @(posedge clock); #1;
    req_key = 32'd77; req_signal = 2'd1; req_value = 32'd5;
    n = 0;
    while (!resp_valid && n < 20) begin @(posedge clock); #1; n++; end
    check("hold_resp_valid", 64'(resp_valid), 64'(1));
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      check("hold_valid", 64'(resp_valid), 64'(1));
      check("hold_req_ready", 64'(req_ready), 64'(0));
      check("hold_value", 64'(resp_value), 64'(hv));
      check("hold_status", 64'(resp_status), 64'(st));
      check("hold_addr", 64'(resp_value_addr), 64'(ra));
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    check("post_resp_valid", 64'(resp_valid), 64'(0));
    check("post_req_ready", 64'(req_ready), 64'(1));
    do_op(32'd77, 2'd2, 32'd0, 1'b0);

    // Reset while the lookup sits in UPDATE.
    wait_ready();
    req_valid = 1'b1; req_key = 32'd249; req_signal = 2'd2;
    @(posedge clock); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin @(posedge clock); #1; end
    check("upd_resp_valid", 64'(resp_valid), 64'(0));
    reset = 1'b1;
    #1;
    check("abort_resp_valid", 64'(resp_valid), 64'(0));
    check("abort_req_ready", 64'(req_ready), 64'(1));
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    do_op(32'd249, 2'd2, 32'd0, 1'b0);

    // Hash collisions and delete.
    do_op(32'd9, 2'd1, 32'd10, 1'b0);
    do_op(32'd25, 2'd1, 32'd20, 1'b0);
    do_op(32'd4121, 2'd1, 32'd30, 1'b0);
    do_op(32'd9, 2'd1, 32'd40, 1'b0);
    do_op(32'd9, 2'd3, 32'd0, 1'b0);
    do_op(32'd9, 2'd2, 32'd0, 1'b0);
    do_op(32'd25, 2'd2, 32'd0, 1'b0);
    do_op(32'd9, 2'd3, 32'd0, 1'b0);

    // Allocator exhaustion: 32 inserts fill both tables.
    apply_reset();
    for (int i = 0; i < 16; i++) do_op(32'(i), 2'd1, 32'(i * 3), 1'b0);
    for (int i = 0; i < 16; i++) do_op(32'h1000 | 32'(i << 4), 2'd1, 32'(i + 500), 1'b0);
    do_op(32'h2000, 2'd1, 32'd1, 1'b0);
    do_op(32'd5, 2'd3, 32'd0, 1'b0);
    do_op(32'h3005, 2'd1, 32'd1, 1'b0);
    do_op(32'h1070, 2'd2, 32'd0, 1'b0);

    // Randomized traffic over a small key pool to force hits and collisions.
    for (int i = 0; i < 20; i++) pool[i] = $urandom & 32'h0000_0FFF;
    for (int r = 0; r < 3; r++) begin
      apply_reset();
      for (int i = 0; i < 100; i++) begin
        hv = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 500));
        do_op(pool[$urandom_range(0, 19)], 2'($urandom_range(0, 3)), hv, 1'($urandom_range(0, 1)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/kv_txn_responder.md
# kv_txn_responder

Request/response key-value transaction engine, the serving end of the key/signal/transact interface that our benches drive into the BRAM store. Accepts one request at a time over a valid/ready handshake and resolves the key through two cuckoo-style hash tables to a value address. It then performs insert, lookup, credit/debit or delete on the value memory and returns a status, value and value address over a second valid/ready handshake. It sits between the transaction sequencer and the ledger memories.

## Interface
- KEY_WIDTH, 32, key width
- VAL_WIDTH, 32, balance width
- ADDR_BITS, 4, index bits per hash table (2^ADDR_BITS slots each)
- VAL_ADDR_BITS, 5, value memory address bits (2^VAL_ADDR_BITS entries)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  engine accepts request
- req_key  in  KEY_WIDTH  key
- req_signal  in  2  0 transact, 1 insert, 2 lookup, 3 delete
- req_value  in  VAL_WIDTH  initial balance (insert) / amount (transact)
- req_kind  in  1  0 credit, 1 debit (transact only)
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_status  out  2  0 OK, 1 NOT_FOUND, 2 FULL, 3 REJECT
- resp_value  out  VAL_WIDTH  resulting/current balance
- resp_value_addr  out  VAL_ADDR_BITS  value address of the key

## Operation
- Hashes: h1 = key[ADDR_BITS-1:0]; h2 = key[2*ADDR_BITS-1:ADDR_BITS] ^ key[3*ADDR_BITS-1:2*ADDR_BITS].
- Each table slot holds a valid bit, key and value address. Valid bits are flops cleared by reset; key, address and value arrays are not reset.
- Value allocator: counter of VAL_ADDR_BITS+1 bits, starts at 0 and increments per successful insert. Exhausted when it equals 2^VAL_ADDR_BITS. Delete never reclaims.
- FSM states: IDLE, PROBE, MATCH, VREAD, UPDATE, RESP.
- IDLE: req_ready=1. On req_valid, latch all request fields and go to PROBE.
- PROBE: read slot h1 of table 1 and slot h2 of table 2, registered.
- MATCH: hit = valid and key equal. Table 1 wins if both hit.
  - Insert, hit: REJECT, with value_addr of the hit.
  - Insert, miss, allocator free, a free slot exists (table 1 preferred): write the slot and value mem[alloc] = req_value, then OK with value = req_value and addr = alloc.
  - Insert, miss, otherwise: FULL, no writes.
  - Delete, hit: clear that valid bit, then OK with addr. Delete, miss: NOT_FOUND.
  - Lookup/transact, hit: go to VREAD. Miss: NOT_FOUND.
  - Every path that does not go to VREAD goes to RESP.
- VREAD: read value mem at the hit address.
- UPDATE:
  - Lookup: OK with value = old.
  - Credit: new = old + amount mod 2^VAL_WIDTH (wraps, no status). Write new, OK with value = new.
  - Debit with amount > old: REJECT with value = old, no write.
  - Debit otherwise: write old − amount, OK.
- RESP: resp_valid=1 with fields stable until resp_ready, then IDLE.
- On NOT_FOUND and FULL, resp_value and resp_value_addr are 0.

## Timing
- Reset values:
  - state IDLE, req_ready 1
  - resp_valid 0, resp_status 0, resp_value 0, resp_value_addr 0
  - all valid bits 0, allocator 0
- Reset mid-operation aborts the request with no response and leaves the tables empty.
- Request accepted on the edge with req_valid & req_ready (cycle 0).
- resp_valid rises:
  - cycle 3 for insert, delete and any miss
  - cycle 5 for lookup and transact
- Response transfers on the edge with resp_valid & resp_ready. req_ready returns the next cycle; minimum request-to-request interval is 4 or 6 cycles.
- req_ready is 0 in every state except IDLE. req_* inputs are ignored outside IDLE.
- Table and value writes take effect at the end of MATCH/UPDATE and are visible to the next request.

## Test plan
- Insert key 249 value 100, then transact credit 50, then lookup -> OK addr 0 value 100; OK value 150; OK value 150. Latencies 3/5/5 cycles.
- Key 249 balance 150, debit 200 -> REJECT value 150, balance unchanged. Debit 150 -> OK value 0. Credit 32'hFFFFFFFF then credit 2 -> value wraps to 1.
- Insert keys 9, 25 (h1 collision, lands table 2 slot 1), then 4121 (h1=9, h2=1) -> OK, OK, FULL. Re-insert 9 -> REJECT.
- Delete 9 -> OK. Lookup 9 -> NOT_FOUND. Lookup 25 -> OK. Delete 9 again -> NOT_FOUND.
- 32 distinct non-colliding inserts -> all OK with addr 0..31. 33rd -> FULL.
- Hold resp_ready low 10 cycles -> response fields stable, req_ready 0, new req_valid ignored. Assert reset during UPDATE -> no response, lookup of a prior key -> NOT_FOUND.
